// File: rtl/dram_ctrl.sv
// 68040 DRAM controller: row/column multiplexing, per-lane CAS, CAS-before-RAS refresh.
// Define DRAM_BURST_EN to run SIZ=11 line transfers as four-beat bursts under one RAS.
module dram_ctrl #(
    parameter int unsigned NBANKS  = 4,
    parameter int unsigned ROW_W   = 12,
    parameter int unsigned COL_W   = 10,
    parameter int unsigned TRCD    = 2,
    parameter int unsigned TCAS    = 2,
    parameter int unsigned TRP     = 3,
    parameter int unsigned REF_INT = 1560
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic [31:0]       A,
    input  logic              sel,
    input  logic              nTS,
    input  logic              RW,
    input  logic [1:0]        SIZ,
    output logic              nTA,
    output logic              nTBI,
    output logic [ROW_W-1:0]  DRAMA,
    output logic [NBANKS-1:0] nRAS,
    output logic [3:0]        nCAS,
    output logic              DRAMRW
);

    localparam int unsigned BANK_W   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int unsigned ROW_LSB  = COL_W + 2;
    localparam int unsigned BANK_LSB = COL_W + ROW_W + 2;
    localparam int unsigned ROW_WR   = (TRCD < 2) ? 2 : TRCD;
    localparam int unsigned CNT_W    = $clog2(TCAS + TRCD + TRP + 2);
    localparam int unsigned REF_W    = (REF_INT > 1) ? $clog2(REF_INT) : 1;

`ifdef DRAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ROW, COL, ACK, PRE, RCAS, RRAS, RPRE} stateT;

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        beat;
    logic [31:0]       aReg;
    logic              rwReg;
    logic [1:0]        sizReg;
    logic              accPend;
    logic [REF_W-1:0]  refCnt;
    logic              refPend;

    logic              startAcc_c;
    logic              lastBeat_c;
    logic [CNT_W-1:0]  rowLast_c;
    logic              unusedAddr_c;

    // Active-low RAS mask for the bank selected by an address.
    function automatic logic [NBANKS-1:0] rasOf(input logic [31:0] addr);
        logic [BANK_W-1:0] bank;
        if (NBANKS == 1) return '0;
        bank = addr[BANK_LSB +: BANK_W];
        return ~(NBANKS'(1) << bank);
    endfunction

    function automatic logic [ROW_W-1:0] rowOf(input logic [31:0] addr);
        return addr[ROW_LSB +: ROW_W];
    endfunction

    // Column for a given beat; the low two bits wrap within the line.
    function automatic logic [ROW_W-1:0] colOf(input logic [31:0] addr, input logic [1:0] bt);
        logic [COL_W-1:0] c;
        c      = addr[2 +: COL_W];
        c[1:0] = addr[3:2] + bt;
        return ROW_W'(c);
    endfunction

    // Active-low CAS lanes; nCAS[3] is D31:24.
    function automatic logic [3:0] lanesOf(input logic [1:0] siz, input logic [1:0] a10);
        case (siz)
            2'b01: begin
                case (a10)
                    2'd0:    return 4'b0111;
                    2'd1:    return 4'b1011;
                    2'd2:    return 4'b1101;
                    default: return 4'b1110;
                endcase
            end
            2'b10:   return a10[1] ? 4'b1100 : 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    assign startAcc_c   = !nTS && sel;
    assign lastBeat_c   = !(BURST && (sizReg == 2'b11)) || (beat == 2'd3);
    // Writes get a second ROW cycle when TRCD=1 so the column settles before nCAS falls.
    assign rowLast_c    = rwReg ? CNT_W'(TRCD - 1) : CNT_W'(ROW_WR - 1);
    assign unusedAddr_c = ^aReg;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            beat    <= '0;
            aReg    <= '0;
            rwReg   <= 1'b1;
            sizReg  <= '0;
            accPend <= 1'b0;
            refCnt  <= '0;
            refPend <= 1'b0;
            nRAS    <= '1;
            nCAS    <= '1;
            nTA     <= 1'b1;
            nTBI    <= 1'b1;
            DRAMRW  <= 1'b1;
            DRAMA   <= '0;
        end else begin
            nRAS <= '1;
            nCAS <= '1;
            nTA  <= 1'b1;
            nTBI <= 1'b1;

            // Free-running refresh timer; a wrap while already pending is absorbed.
            if (refCnt == REF_W'(REF_INT - 1)) begin
                refCnt  <= '0;
                refPend <= 1'b1;
            end else begin
                refCnt <= refCnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (startAcc_c) begin
                        aReg    <= A;
                        rwReg   <= RW;
                        sizReg  <= SIZ;
                        accPend <= 1'b1;
                        beat    <= '0;
                    end
                    if (refPend) begin
                        state <= RCAS;
                        cnt   <= '0;
                        nCAS  <= '0;
                    end else if (startAcc_c) begin
                        state  <= ROW;
                        cnt    <= '0;
                        nRAS   <= rasOf(A);
                        DRAMA  <= rowOf(A);
                        DRAMRW <= RW;
                    end
                end
                ROW: begin
                    nRAS  <= rasOf(aReg);
                    DRAMA <= colOf(aReg, beat);
                    if (cnt == rowLast_c) begin
                        state <= COL;
                        cnt   <= '0;
                        nCAS  <= lanesOf(sizReg, aReg[1:0]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COL: begin
                    nRAS <= rasOf(aReg);
                    if (cnt == CNT_W'(TCAS - 1)) begin
                        state <= ACK;
                        cnt   <= '0;
                        nTA   <= 1'b0;
                        nTBI  <= !(!BURST && (sizReg == 2'b11));
                        if (!lastBeat_c) DRAMA <= colOf(aReg, beat + 2'd1);
                    end else begin
                        cnt  <= cnt + 1'b1;
                        nCAS <= lanesOf(sizReg, aReg[1:0]);
                    end
                end
                ACK: begin
                    cnt <= '0;
                    if (lastBeat_c) begin
                        state   <= PRE;
                        accPend <= 1'b0;
                    end else begin
                        state <= COL;
                        beat  <= beat + 2'd1;
                        nRAS  <= rasOf(aReg);
                        nCAS  <= lanesOf(sizReg, aReg[1:0]);
                    end
                end
                PRE: begin
                    if (cnt == CNT_W'(TRP - 1)) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        DRAMRW <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RCAS: begin
                    state <= RRAS;
                    cnt   <= '0;
                    nRAS  <= '0;
                    nCAS  <= '0;
                end
                RRAS: begin
                    if (cnt == CNT_W'(TCAS + TRCD - 1)) begin
                        state <= RPRE;
                        cnt   <= '0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        nRAS <= '0;
                        nCAS <= '0;
                    end
                end
                RPRE: begin
                    if (cnt == CNT_W'(TRP - 1)) begin
                        refPend <= 1'b0;
                        cnt     <= '0;
                        // An access held back by the refresh starts right away.
                        if (accPend) begin
                            state  <= ROW;
                            nRAS   <= rasOf(aReg);
                            DRAMA  <= rowOf(aReg);
                            DRAMRW <= rwReg;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 Parameter NBANKS, 4, number of RAS banks, 1 to 8.
REQ-002 Parameter ROW_W, 12, row address bits; DRAMA width.
REQ-003 Parameter COL_W, 10, column address bits, <= ROW_W.
REQ-004 Parameter TRCD, 2, clocks from nRAS fall to nCAS fall, >= 1.
REQ-005 Parameter TCAS, 2, clocks nCAS held low per beat, >= 1.
REQ-006 Parameter TRP, 3, precharge clocks with all nRAS high, >= 1.
REQ-007 Parameter REF_INT, 1560, clocks between refresh requests.
REQ-008 Port clk, input, 1, single clock; all state changes on the rising edge.
REQ-009 Port nRESET, input, 1, reset, asynchronous, active-low.
REQ-010 Port A, input, 32, 68040 address.
REQ-011 Port sel, input, 1, DRAM region select from the address decoder.
REQ-012 Ports nTS, RW, SIZ; input; 1, 1, 2; transfer start, read/nwrite, transfer size.
REQ-013 Ports nTA, nTBI; output; 1, 1; transfer acknowledge, burst inhibit.
REQ-014 Port DRAMA, output, ROW_W, multiplexed row/column address.
REQ-015 Ports nRAS, nCAS; output; NBANKS, 4; row strobes per bank, column strobes per byte lane (nCAS[3] = D31:24).
REQ-016 Port DRAMRW, output, 1, DRAM read/nwrite.

Function
REQ-017 Address map: column = A[COL_W+1:2], row = A[COL_W+ROW_W+1:COL_W+2], bank = next log2(NBANKS) bits.
REQ-018 FSM states: IDLE, ROW, COL, ACK, PRE, RCAS, RRAS, RPRE.
REQ-019 IDLE: nTS=0 and sel=1 at an edge latch A, RW, SIZ; next cycle ROW with the selected nRAS low, DRAMA = row, DRAMRW = latched RW.
REQ-020 ROW lasts TRCD cycles; COL drives DRAMA = zero-extended column and asserts the lane nCAS for TCAS cycles; ACK drives nTA low for exactly one cycle.
REQ-021 Lanes: SIZ 01 byte -> lane 3-A[1:0]; SIZ 10 word -> lanes 3,2 if A[1]=0, else 1,0; SIZ 00 or 11 -> all four lanes.
REQ-022 After the final ACK: PRE, with all nRAS and nCAS high for TRP cycles, then IDLE.
REQ-023 Refresh counter: counts 0..REF_INT-1, then wraps; the wrap sets the pending flag. A further wrap while pending is not queued.
REQ-024 Pending refresh in IDLE runs RCAS: all nCAS low for 1 cycle. RRAS follows: all nRAS low for TCAS+TRCD cycles. RPRE follows: all strobes high for TRP cycles, flag cleared.
REQ-025 If nTS and pending refresh coincide in IDLE, refresh runs first. The access stays latched and starts at ROW immediately after RPRE.
REQ-026 nTS while sel=0 or while not IDLE is ignored. No latched access is ever dropped.
REQ-027 Writes: nCAS falls only after DRAMA holds the column for at least one cycle. DRAMRW is held from ROW through PRE.

Reset
REQ-028 nRESET low at any time forces immediately: IDLE, nRAS/nCAS all 1, nTA=1, nTBI=1, DRAMRW=1, DRAMA=0, refresh counter 0, pending 0, latched access discarded.
REQ-029 On nRESET release, nothing occurs before the first nTS or the first refresh wrap.

Configuration
REQ-030 Macro DRAM_BURST_EN defined, SIZ=11: four beats (COL+ACK per beat) under one RAS. Column bits [1:0] increment modulo 4 from A[3:2]; nTBI=1.
REQ-031 Macro DRAM_BURST_EN undefined, SIZ=11: single beat, with nTBI driven low in the same cycle as nTA. Other sizes are identical in both builds.

Verification
REQ-032 Long read, default parameters, A=0x00012344, sel=1: nRAS[0] low 1 cycle after nTS; nCAS=0000 after 2 cycles; nTA low 1 cycle; then 3 precharge cycles.
REQ-033 Byte write, A=0x00000003, RW=0, SIZ=01: only nCAS[0] falls; DRAMRW=0 throughout ROW..PRE.
REQ-034 Line read with DRAM_BURST_EN, A[3:2]=10: column low bits are 2,3,0,1; 4 nTA pulses; nTBI stays 1. Without the macro: 1 nTA, with nTBI=0.
REQ-035 REF_INT=16, nTS in the pending-refresh cycle: RCAS, RRAS, RPRE run first, then the access with correct data lanes; no access lost.
REQ-036 nRESET low during COL of a burst: all strobes high and nTA=1 within the same cycle; next access after release behaves as in REQ-032.
